// File: rtl/mc_control_pkg.sv
// Shared MIPS definitions for the multicycle control path: opcodes, ALUOp and
// mux encodings, the FSM state encoding and the datapath control word.
package mc_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ASB_REG_B  = 2'b00;
   localparam logic [1:0] ASB_FOUR   = 2'b01;
   localparam logic [1:0] ASB_IMM    = 2'b10;
   localparam logic [1:0] ASB_IMM_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEMADR   = 4'd3,
      ST_MEMRD    = 4'd4,
      ST_MEMWB    = 4'd5,
      ST_MEMWR    = 4'd6,
      ST_RTYPE_EX = 4'd7,
      ST_RTYPE_WB = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JUMP     = 4'd10,
      ST_ADDI_EX  = 4'd11,
      ST_ADDI_WB  = 4'd12,
      ST_HALT     = 4'd15
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Combinational state -> control word decode. Everything is a Moore decode of
// state except the FETCH write enables and the DECODE illegal-opcode flag.
module mc_control_decode
   import mc_control_pkg::*;
(
   input  state_e     state_i,
   input  logic       mem_ready_i,
   input  logic [5:0] op_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = ASB_FOUR;
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.pc_source = PCS_ALU;
            // IR and PC only advance on the cycle memory delivers the word.
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         ST_DECODE: begin
            ctrl_o.alu_src_b  = ASB_IMM_SH;
            ctrl_o.alu_op     = ALUOP_ADD;
            ctrl_o.illegal_op = !is_legal_op(op_i);
         end
         ST_MEMADR, ST_ADDI_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ASB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         ST_MEMRD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         ST_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
         end
         ST_RTYPE_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ASB_REG_B;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         ST_RTYPE_WB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         ST_ADDI_WB: begin
            ctrl_o.reg_write = 1'b1;
         end
         ST_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = ASB_REG_B;
            ctrl_o.alu_op        = ALUOP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCS_ALUOUT;
         end
         ST_JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCS_JUMP;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback one state per cycle, stalling on mem_ready in FETCH/MEMRD/MEMWR.
module mc_control
   import mc_control_pkg::*;
#(
   parameter bit ILLEGAL_TRAP = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state_o
);

   state_e state_q;
   ctrl_t  ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   state_q <= ST_FETCH;
            ST_FETCH:  state_q <= mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
               case (op)
                  OP_LW, OP_SW: state_q <= ST_MEMADR;
                  OP_RTYPE:     state_q <= ST_RTYPE_EX;
                  OP_BEQ:       state_q <= ST_BRANCH;
                  OP_J:         state_q <= ST_JUMP;
                  OP_ADDI:      state_q <= ST_ADDI_EX;
                  default:      state_q <= ILLEGAL_TRAP ? ST_HALT : ST_FETCH;
               endcase
            end
            ST_MEMADR:   state_q <= (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:    state_q <= mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:    state_q <= ST_FETCH;
            ST_MEMWR:    state_q <= mem_ready ? ST_FETCH : ST_MEMWR;
            ST_RTYPE_EX: state_q <= ST_RTYPE_WB;
            ST_RTYPE_WB: state_q <= ST_FETCH;
            ST_BRANCH:   state_q <= ST_FETCH;
            ST_JUMP:     state_q <= ST_FETCH;
            ST_ADDI_EX:  state_q <= ST_ADDI_WB;
            ST_ADDI_WB:  state_q <= ST_FETCH;
            ST_HALT:     state_q <= ST_HALT;
            // Unused encodings recover through IDLE.
            default:     state_q <= ST_IDLE;
         endcase
      end
   end

   mc_control_decode u_decode (
      .state_i     (state_q),
      .mem_ready_i (mem_ready),
      .op_i        (op),
      .ctrl_o      (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign illegal_op    = ctrl.illegal_op;
   assign state_o       = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a per-cycle vector table covering every
// instruction class plus hand-written HALT and async-reset sequences.
module tb_mc_control;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic       mem_ready;

   logic       pcw0, pcc0, iod0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0, ill0;
   logic [1:0] asb0, aop0, psrc0;
   logic [3:0] st0;
   logic       pcw1, pcc1, iod1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, ill1;
   logic [1:0] asb1, aop1, psrc1;
   logic [3:0] st1;

   mc_control #(.ILLEGAL_TRAP(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .pc_write(pcw0), .pc_write_cond(pcc0), .i_or_d(iod0), .mem_read(mrd0),
      .mem_write(mwr0), .ir_write(irw0), .mem_to_reg(m2r0), .reg_dst(rdst0),
      .reg_write(rw0), .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0),
      .pc_source(psrc0), .illegal_op(ill0), .state_o(st0)
   );

   mc_control #(.ILLEGAL_TRAP(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .pc_write(pcw1), .pc_write_cond(pcc1), .i_or_d(iod1), .mem_read(mrd1),
      .mem_write(mwr1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rdst1),
      .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1),
      .pc_source(psrc1), .illegal_op(ill1), .state_o(st1)
   );

   // Control word packing: pcw,pcc,iod,mrd,mwr,irw,m2r,rdst,rw,asa,asb,aop,psrc,ill
   logic [16:0] cw0, cw1;
   assign cw0 = {pcw0, pcc0, iod0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0,
                 asb0, aop0, psrc0, ill0};
   assign cw1 = {pcw1, pcc1, iod1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1,
                 asb1, aop1, psrc1, ill1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [16:0] cw(input logic pcw, input logic pcc, input logic iod,
                                      input logic mrd, input logic mwr, input logic irw,
                                      input logic m2r, input logic rdst, input logic rw,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic [1:0] psrc,
                                      input logic ill);
      return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
   endfunction

   typedef struct {
      logic [5:0]  op;
      logic        mr;
      logic [3:0]  st;
      logic [16:0] cw;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [5:0] o, input logic m, input logic [3:0] s,
                      input logic [16:0] c);
      vec_t v;
      v.op = o; v.mr = m; v.st = s; v.cw = c;
      vecs.push_back(v);
   endtask

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
   localparam logic [5:0] JNK = 6'b111111;

   initial begin
      logic [16:0] c_fetch_r, c_fetch_w, c_dec, c_dec_ill, c_madr, c_mrd, c_mwb;
      logic [16:0] c_mwr, c_rex, c_rwb, c_br, c_jmp, c_aex, c_awb;
      int ill_idx;

      c_fetch_r = cw(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
      c_fetch_w = cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
      c_dec     = cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
      c_dec_ill = cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
      c_madr    = cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
      c_mrd     = cw(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
      c_mwb     = cw(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
      c_mwr     = cw(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
      c_rex     = cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
      c_rwb     = cw(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
      c_br      = cw(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
      c_jmp     = cw(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
      c_aex     = cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
      c_awb     = cw(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);

      // lw, mem_ready high: 0,1,2,3,4,5
      add(JNK,1,4'd0,'0);   add(JNK,1,4'd1,c_fetch_r); add(LW,1,4'd2,c_dec);
      add(LW,1,4'd3,c_madr); add(JNK,1,4'd4,c_mrd);   add(JNK,1,4'd5,c_mwb);
      // sw: 3 stall cycles in FETCH, 2 in MEMWR -> 9 cycles total
      add(JNK,0,4'd1,c_fetch_w); add(JNK,0,4'd1,c_fetch_w); add(JNK,0,4'd1,c_fetch_w);
      add(JNK,1,4'd1,c_fetch_r); add(SW,1,4'd2,c_dec);      add(SW,1,4'd3,c_madr);
      add(JNK,0,4'd6,c_mwr);     add(JNK,0,4'd6,c_mwr);     add(JNK,1,4'd6,c_mwr);
      // R-type (mem_ready ignored in EX/WB)
      add(JNK,1,4'd1,c_fetch_r); add(RT,1,4'd2,c_dec); add(JNK,0,4'd7,c_rex);
      add(JNK,0,4'd8,c_rwb);
      // beq, j
      add(JNK,1,4'd1,c_fetch_r); add(BEQ,1,4'd2,c_dec); add(JNK,1,4'd9,c_br);
      add(JNK,1,4'd1,c_fetch_r); add(JMP,1,4'd2,c_dec); add(JNK,1,4'd10,c_jmp);
      // addi
      add(JNK,1,4'd1,c_fetch_r); add(ADDI,1,4'd2,c_dec); add(JNK,1,4'd11,c_aex);
      add(JNK,1,4'd12,c_awb);
      // illegal opcode
      add(JNK,1,4'd1,c_fetch_r); add(JNK,1,4'd2,c_dec_ill);
      ill_idx = vecs.size() - 1;
      add(JNK,0,4'd1,c_fetch_w);
      add(LW,0,4'd1,c_fetch_w);

      rst_n = 1'b0; op = JNK; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_state0", 32'(st0), 32'd0);
      check("reset_cw0", 32'(cw0), 32'd0);
      check("reset_state1", 32'(st1), 32'd0);
      check("reset_cw1", 32'(cw1), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         op = vecs[i].op;
         mem_ready = vecs[i].mr;
         #1;
         check($sformatf("vec%0d_state0", i), 32'(st0), 32'(vecs[i].st));
         check($sformatf("vec%0d_cw0", i), 32'(cw0), 32'(vecs[i].cw));
         if (i <= ill_idx) begin
            check($sformatf("vec%0d_state1", i), 32'(st1), 32'(vecs[i].st));
            check($sformatf("vec%0d_cw1", i), 32'(cw1), 32'(vecs[i].cw));
         end else begin
            check($sformatf("vec%0d_halt_state1", i), 32'(st1), 32'd15);
            check($sformatf("vec%0d_halt_cw1", i), 32'(cw1), 32'd0);
         end
         @(negedge clk);
      end

      // HALT is sticky regardless of op/mem_ready
      for (int k = 0; k < 4; k++) begin
         op = (k % 2 == 0) ? LW : 6'(k * 7);
         mem_ready = k[0];
         #1;
         check($sformatf("halt_hold%0d_state1", k), 32'(st1), 32'd15);
         check($sformatf("halt_hold%0d_cw1", k), 32'(cw1), 32'd0);
         @(negedge clk);
      end

      rst_n = 1'b0;
      #1;
      check("halt_reset_state1", 32'(st1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op = SW; mem_ready = 1'b1;
      #1;
      check("post_reset_idle0", 32'(st0), 32'd0);
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      begin
         int budget;
         budget = 0;
         while (st0 != 4'd6 && budget < 8) begin
            @(negedge clk);
            budget++;
         end
         check("reach_memwr_state0", 32'(st0), 32'd6);
      end
      #1;
      check("memwr_hold_mwr0", 32'(mwr0), 32'd1);
      @(posedge clk);
      #2;
      check("memwr_stalled_state0", 32'(st0), 32'd6);
      rst_n = 1'b0;
      #1;
      check("async_rst_mwr0", 32'(mwr0), 32'd0);
      check("async_rst_state0", 32'(st0), 32'd0);
      check("async_rst_mwr1", 32'(mwr1), 32'd0);
      check("async_rst_cw1", 32'(cw1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("release_idle0", 32'(st0), 32'd0);
      check("release_idle_cw0", 32'(cw0), 32'd0);
      @(negedge clk);
      #1;
      check("release_fetch0", 32'(st0), 32'd1);
      check("release_fetch1", 32'(st1), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback, one step per cycle.
- Sits directly upstream of alucontrol: drives the 2-bit ALUOp (00 add, 01 sub, 10 use Funct) and all datapath mux/write enables.
- Stalls on a memory ready handshake.

Parameters:
- ILLEGAL_TRAP, 0, 1: an illegal opcode enters sticky HALT until reset. 0: an illegal opcode returns to FETCH after flagging.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op  input  6  instruction opcode, IR[31:26]; valid from DECODE onward
- mem_ready  input  1  memory completed the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU Zero (beq)
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback data select: 1 = MDR
- reg_dst  output  1  destination register select: 1 = rd, 0 = rt
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = reg A
- alu_src_b  output  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  output  2  to alucontrol
- pc_source  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse on an unknown opcode
- state_o  output  4  current state, for debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0, including state_o=0 and illegal_op=0. Asserting reset mid-instruction aborts the instruction immediately; no write enable survives the reset edge.
- IDLE: all outputs 0; next state is FETCH unconditionally.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> RTYPE_EX
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 (addi) -> ADDI_EX
    - any other op: illegal_op=1 this cycle; next state is HALT if ILLEGAL_TRAP=1, else FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Hold while mem_ready=0; next MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold while mem_ready=0; next FETCH.
  - mem_write stays high throughout the hold.
  - Memory samples the write on the mem_ready cycle only.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Next RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- HALT: all outputs 0; remains in HALT until reset.
- Output rules:
  - Any output not listed for a state is 0.
  - Outputs are Moore decodes of state, except ir_write/pc_write in FETCH, which are qualified by mem_ready.
  - op is sampled only in DECODE and MEMADR; op changes in other states have no effect.
- Instruction latencies, mem_ready tied high: lw 5 cycles; sw, R-type, addi 4; beq, j 3. Each mem_ready=0 cycle adds one cycle.
- State encoding (state_o):
  - IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6
  - RTYPE_EX 7, RTYPE_WB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12, HALT 15

Decomposition:
- Shared package/header (mips_defs):
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - alu_src_b and pc_source encodings
  - the state encoding
- One sub-module is natural: mc_control_decode, the combinational state -> control-word decode. The FSM next-state logic stays in mc_control.

Test Plan:
- Reset, then op=100011, mem_ready=1 -> state_o sequence 0,1,2,3,4,5,1. reg_write=1 and mem_to_reg=1 only in state 5. alu_op=00 throughout.
- op=000000 with Funct=100010 applied to alucontrol, A=10, B=6 -> alu_op=10 in state 7; ALU result 4 latched; reg_write=1 with reg_dst=1 in state 8.
- op=000100, A=B=5 -> in state 9: alu_op=01, pc_write_cond=1, pc_source=01, Zero=1. Back to FETCH next cycle.
- mem_ready low for 3 cycles during FETCH, then sw with mem_ready low 2 cycles in MEMWR:
  - ir_write and pc_write pulse exactly once in FETCH.
  - mem_write is held 3 cycles.
  - Total instruction latency is 4+3+2=9 cycles.
- op=111111:
  - ILLEGAL_TRAP=0 -> illegal_op pulses 1 cycle in DECODE, then state 1.
  - ILLEGAL_TRAP=1 -> state 15 with all outputs 0 until rst_n low.
- rst_n deasserted asynchronously mid-MEMWR (between clock edges) -> mem_write and state_o are 0 immediately, before the next clock edge. After release: one IDLE cycle, then FETCH.
